// File: rtl/tx_frame_arbiter_pkg.sv
// rtl/tx_frame_arbiter_pkg.sv - shared types for the tx frame arbiter
package tx_frame_arbiter_pkg;

   // ARB_ prefix keeps these literals apart from other FSM enums in the MAC path
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_SEND  = 2'd1,
      ARB_DRAIN = 2'd2,
      ARB_GAP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/tx_frame_arbiter_rr_pointer_pick.sv
// rtl/tx_frame_arbiter_rr_pointer_pick.sv - first requester at or above ptr, wrapping
module rr_pointer_pick #(
   parameter int NUM_SRC = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W:0] sum;

   // Walk downward so the candidate closest to ptr is written last and wins
   always_comb begin
      idx = '0;
      any = 1'b0;
      sum = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(NUM_SRC)) begin
            sum = sum - (IDX_W + 1)'(NUM_SRC);
         end
         if (req[sum[IDX_W-1:0]]) begin
            idx = sum[IDX_W-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - frame-locked round-robin arbiter onto the MAC tx_axis port
module tx_frame_arbiter
   import tx_frame_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 1518,
   parameter int IFG_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
   input  logic [NUM_SRC-1:0]          s_tvalid,
   input  logic [NUM_SRC-1:0]          s_tlast,
   output logic [NUM_SRC-1:0]          s_tready,
   output logic [DATA_W-1:0]           m_tdata,
   output logic                        m_tvalid,
   output logic                        m_tlast,
   input  logic                        m_tready,
   input  logic [IFG_W-1:0]            ifg_cycles,
   output logic                        grant_valid,
   output logic [$clog2(NUM_SRC)-1:0]  grant_idx,
   output logic                        frame_done,
   output logic                        oversize_err
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IFG_W-1:0] gap_q, gap_d;

   logic [DATA_W-1:0] src_data [NUM_SRC];
   logic [DATA_W-1:0] sel_data;
   logic              sel_valid, sel_last, forced_last, beat_acc, frame_end;
   logic [IDX_W-1:0]  pick_idx, next_ptr;
   logic              pick_any;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign src_data[i] = s_tdata[i*DATA_W +: DATA_W];
   end

   assign sel_data    = src_data[grant_q];
   assign sel_valid   = s_tvalid[grant_q];
   assign sel_last    = s_tlast[grant_q];
   assign forced_last = (len_q == LEN_W'(MAX_LEN - 1));
   assign beat_acc    = (state_q == ARB_SEND) & sel_valid & m_tready;
   assign next_ptr    = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

   rr_pointer_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req (s_tvalid),
      .ptr (rr_ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         len_q    <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         len_q    <= len_d;
         gap_q    <= gap_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      len_d     = len_q;
      gap_d     = gap_q;
      frame_end = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               len_d   = '0;
               state_d = ARB_SEND;
            end
         end
         ARB_SEND: begin
            if (beat_acc) begin
               len_d = len_q + 1'b1;
               if (sel_last) begin
                  frame_end = 1'b1;
               end else if (forced_last) begin
                  state_d = ARB_DRAIN;
               end
            end
         end
         ARB_DRAIN: begin
            if (sel_valid && sel_last) begin
               frame_end = 1'b1;
            end
         end
         ARB_GAP: begin
            gap_d = gap_q - 1'b1;
            if (gap_q == IFG_W'(1)) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // ifg_cycles is only looked at here, so changing it mid-gap has no effect
      if (frame_end) begin
         rr_ptr_d = next_ptr;
         if (ifg_cycles == '0) begin
            state_d = ARB_IDLE;
         end else begin
            gap_d   = ifg_cycles;
            state_d = ARB_GAP;
         end
      end
   end

   always_comb begin
      s_tready     = '0;
      m_tdata      = '0;
      m_tvalid     = 1'b0;
      m_tlast      = 1'b0;
      grant_valid  = 1'b0;
      grant_idx    = grant_q;
      frame_done   = 1'b0;
      oversize_err = 1'b0;
      case (state_q)
         ARB_SEND: begin
            grant_valid       = 1'b1;
            s_tready[grant_q] = m_tready;
            m_tdata           = sel_data;
            m_tvalid          = sel_valid;
            m_tlast           = sel_last | forced_last;
            frame_done        = beat_acc & (sel_last | forced_last);
            oversize_err      = beat_acc & forced_last & ~sel_last;
         end
         ARB_DRAIN: begin
            grant_valid       = 1'b1;
            s_tready[grant_q] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - self-checking bench for tx_frame_arbiter
module tb_tx_frame_arbiter;

   localparam int NUM_SRC = 2;
   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 8;
   localparam int IFG_W   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_tdata;
   logic [1:0]  s_tvalid, s_tlast, s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast, m_tready;
   logic [3:0]  ifg_cycles;
   logic        grant_valid;
   logic [0:0]  grant_idx;
   logic        frame_done, oversize_err;

   always #5 clk = ~clk;

   tx_frame_arbiter #(
      .NUM_SRC (NUM_SRC),
      .DATA_W  (DATA_W),
      .MAX_LEN (MAX_LEN),
      .IFG_W   (IFG_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tlast      (m_tlast),
      .m_tready     (m_tready),
      .ifg_cycles   (ifg_cycles),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .frame_done   (frame_done),
      .oversize_err (oversize_err)
   );

   typedef struct { logic [7:0] data; logic last; } beat_t;
   typedef struct { int src; logic [7:0] data; logic last; logic ovs; } exp_t;
   typedef struct { int len; int base; } frame_t;

   beat_t  src_q [2][$];
   frame_t pend  [2][$];
   exp_t   exp_q [$];
   int     mptr = 0;
   int     seed_base = 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Source frames: byte b of a frame is base+b, so every frame is distinguishable
   function automatic void add_frame(input int s, input int len);
      beat_t  bt;
      frame_t fr;
      for (int b = 0; b < len; b++) begin
         bt.data = 8'(seed_base + b);
         bt.last = (b == len - 1);
         src_q[s].push_back(bt);
      end
      fr.len  = len;
      fr.base = seed_base;
      pend[s].push_back(fr);
      seed_base += 23;
   endfunction

   // Round-robin over pending frames; truncated frames end at MAX_LEN with an error flag
   function automatic void model_run();
      frame_t fr;
      exp_t   e;
      int     g, n;
      while (pend[0].size() + pend[1].size() > 0) begin
         g = -1;
         for (int k = 0; k < 2; k++) begin
            if (g < 0 && pend[(mptr + k) % 2].size() > 0) g = (mptr + k) % 2;
         end
         fr = pend[g].pop_front();
         n  = (fr.len > MAX_LEN) ? MAX_LEN : fr.len;
         for (int b = 0; b < n; b++) begin
            e.src  = g;
            e.data = 8'(fr.base + b);
            e.last = (b == n - 1);
            e.ovs  = (fr.len > MAX_LEN) && (b == n - 1);
            exp_q.push_back(e);
         end
         mptr = (g + 1) % 2;
      end
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         src_q[i].delete();
         pend[i].delete();
      end
      mptr = 0;
   endfunction

   logic       stall_en = 1'b0;
   logic       rdy_rand = 1'b0;
   logic [1:0] first = 2'b11;
   logic [1:0] hs;

   initial begin
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      forever begin
         @(negedge clk);
         hs = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rst) begin
            s_tvalid = '0;
            s_tlast  = '0;
            s_tdata  = '0;
            first    = 2'b11;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (hs[i]) begin
                  first[i] = src_q[i][0].last;
                  void'(src_q[i].pop_front());
               end
               if (s_tvalid[i] && !hs[i]) begin
                  // beat offered but not taken: hold it unchanged
               end else if (src_q[i].size() == 0) begin
                  s_tvalid[i] = 1'b0;
               end else if (stall_en && !first[i] && $urandom_range(0, 2) == 0) begin
                  s_tvalid[i] = 1'b0;
               end else begin
                  s_tvalid[i]          = 1'b1;
                  s_tdata[i*8 +: 8]    = src_q[i][0].data;
                  s_tlast[i]           = src_q[i][0].last;
               end
            end
         end
      end
   end

   int         cyc = 0;
   int         end_cyc = -100;
   int         gap_meas = -1;
   int         beats_acc = 0;
   int         frames = 0;
   int         ovs_cnt = 0;
   int         done_log [$];
   logic       stalled_prev = 1'b0;
   logic       expect_first = 1'b1;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stalled_prev = 1'b0;
         expect_first = 1'b1;
      end else begin
         cyc++;
         if (stalled_prev) begin
            chk("stall_valid", 32'(m_tvalid), 1);
            chk("stall_data", 32'(m_tdata), 32'(prev_data));
            chk("stall_last", 32'(m_tlast), 32'(prev_last));
         end
         if (grant_valid) chk("ready_only_owner", 32'(s_tready & ~(2'b01 << grant_idx)), 0);
         else chk("ready_without_grant", 32'(s_tready), 0);
         if (m_tvalid) chk("grant_on_beat", 32'(grant_valid), 1);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_src", 32'(grant_idx), 32'(e.src));
               chk("beat_data", 32'(m_tdata), 32'(e.data));
               chk("beat_last", 32'(m_tlast), 32'(e.last));
               chk("beat_done", 32'(frame_done), 32'(e.last));
               chk("beat_ovs", 32'(oversize_err), 32'(e.ovs));
            end
            beats_acc++;
            if (expect_first) gap_meas = cyc - end_cyc - 1;
            expect_first = m_tlast;
            if (m_tlast) begin
               end_cyc = cyc;
               frames++;
               done_log.push_back(int'(grant_idx));
            end
            if (oversize_err) ovs_cnt++;
         end else begin
            chk("done_without_beat", 32'(frame_done), 0);
            chk("ovs_without_beat", 32'(oversize_err), 0);
         end
         stalled_prev = m_tvalid & ~m_tready;
         prev_data    = m_tdata;
         prev_last    = m_tlast;
      end
   end

   task automatic wait_idle(input string name, input int budget);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk);
         #2;
         n++;
         ok = (exp_q.size() == 0) && (src_q[0].size() == 0) && (src_q[1].size() == 0) && !grant_valid;
      end
      chk(name, 32'(ok), 1);
   endtask

   task automatic wait_beats(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (beats_acc < target && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk(name, 32'(beats_acc >= target), 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
      chk({tag, "_m_tdata"}, 32'(m_tdata), 0);
      chk({tag, "_m_tlast"}, 32'(m_tlast), 0);
      chk({tag, "_s_tready"}, 32'(s_tready), 0);
      chk({tag, "_grant_valid"}, 32'(grant_valid), 0);
      chk({tag, "_grant_idx"}, 32'(grant_idx), 0);
      chk({tag, "_frame_done"}, 32'(frame_done), 0);
      chk({tag, "_oversize_err"}, 32'(oversize_err), 0);
   endtask

   int b0, f0, o0, n0;

   initial begin
      ifg_cycles = '0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      // single 4-beat frame from src0
      b0 = beats_acc; f0 = frames;
      add_frame(0, 4);
      model_run();
      wait_idle("t1_idle", 200);
      chk("t1_beats", 32'(beats_acc - b0), 4);
      chk("t1_frames", 32'(frames - f0), 1);
      chk("t1_grant", 32'(done_log[done_log.size() - 1]), 0);

      // both sources busy from reset, strict alternation
      @(negedge clk); rst = 1'b1; model_clear();
      repeat (2) @(negedge clk); rst = 1'b0;
      n0 = done_log.size();
      add_frame(0, 3); add_frame(1, 3); add_frame(0, 3); add_frame(1, 3);
      model_run();
      wait_idle("t2_idle", 300);
      chk("t2_order0", 32'(done_log[n0]), 0);
      chk("t2_order1", 32'(done_log[n0 + 1]), 1);
      chk("t2_order2", 32'(done_log[n0 + 2]), 0);
      chk("t2_order3", 32'(done_log[n0 + 3]), 1);
      chk("t2_gap_b2b", 32'(gap_meas), 1);

      // five idle cycles plus the arbitration cycle between frames
      ifg_cycles = 4'd5;
      add_frame(0, 3); add_frame(1, 2);
      model_run();
      wait_idle("t3_idle", 300);
      chk("t3_gap", 32'(gap_meas), 6);

      // oversize truncation, drain, then a frame of exactly MAX_LEN
      ifg_cycles = '0;
      b0 = beats_acc; o0 = ovs_cnt; n0 = done_log.size();
      add_frame(1, 12);
      model_run();
      wait_beats("t4_start", b0 + 3, 100);
      add_frame(0, 2); add_frame(1, 8);
      model_run();
      wait_idle("t4_idle", 300);
      chk("t4_beats", 32'(beats_acc - b0), 18);
      chk("t4_ovs", 32'(ovs_cnt - o0), 1);
      chk("t4_order0", 32'(done_log[n0]), 1);
      chk("t4_order1", 32'(done_log[n0 + 1]), 0);
      chk("t4_order2", 32'(done_log[n0 + 2]), 1);

      // random backpressure and source bubbles
      ifg_cycles = 4'd2; rdy_rand = 1'b1; stall_en = 1'b1;
      o0 = ovs_cnt;
      add_frame(0, 5); add_frame(1, 1); add_frame(0, 7);
      add_frame(1, 10); add_frame(0, 8); add_frame(1, 3);
      model_run();
      wait_idle("t5_idle", 3000);
      chk("t5_ovs", 32'(ovs_cnt - o0), 1);
      rdy_rand = 1'b0; stall_en = 1'b0; ifg_cycles = '0;
      repeat (4) @(negedge clk);

      // reset in the middle of a frame
      b0 = beats_acc;
      add_frame(1, 6);
      model_run();
      wait_beats("t6_start", b0 + 2, 100);
      chk("t6_busy", 32'(grant_valid), 1);
      rst = 1'b1;
      #1;
      check_zero_outputs("t6_async");
      model_clear();
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      n0 = done_log.size();
      add_frame(1, 3); add_frame(0, 3);
      model_run();
      wait_idle("t6_idle", 300);
      chk("t6_first_after_rst", 32'(done_log[n0]), 0);
      chk("t6_second_after_rst", 32'(done_log[n0 + 1]), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
